// File: rtl/nobl_pkg.sv
// Shared types and burst-order helper for the NoBL SRAM model.
package nobl_pkg;

  typedef enum logic [2:0] {
    DESEL    = 3'd0,
    LOAD_RD  = 3'd1,
    LOAD_WR  = 3'd2,
    BURST_RD = 3'd3,
    BURST_WR = 3'd4
  } op_t;

  // Interleaved order from an odd origin walks 1->0->3->2, i.e. a 2-bit decrement.
  function automatic logic [1:0] next_offset(input logic [1:0] off, input logic interleaved);
    return interleaved ? off - 2'd1 : off + 2'd1;
  endfunction

endpackage

// File: rtl/nobl_burst_addr.sv
// Burst address generator: loaded upper address bits, origin bit and 2-bit offset counter.
module nobl_burst_addr
  import nobl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_adv,
  input  logic          i_mode,
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] o_addr
);

  logic [AW-3:0] r_upper;
  logic          r_org;
  logic [1:0]    r_off;
  logic [1:0]    w_next_off;

  assign w_next_off = next_offset(r_off, i_mode & r_org);
  assign o_addr     = i_load ? i_addr : {r_upper, w_next_off};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upper <= '0;
      r_org   <= 1'b0;
      r_off   <= 2'd0;
    end else if (i_load) begin
      r_upper <= i_addr[AW-1:2];
      r_org   <= i_addr[0];
      r_off   <= i_addr[1:0];
    end else if (i_adv) begin
      r_off   <= w_next_off;
    end
  end

endmodule

// File: rtl/nobl_sram_param.sv
// NoBL synchronous SRAM with byte-lane writes and 2-bit linear/interleaved bursts.
// Define NOBL_PIPE_OUT_EN for a registered output stage (read latency 2).
module nobl_sram_param
  import nobl_pkg::*;
#(
  parameter int DW = 18,
  parameter int BW = 9,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen_n,
  input  logic             ce,
  input  logic             adv_ld,
  input  logic             we_n,
  input  logic [DW/BW-1:0] bws_n,
  input  logic             mode,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             rvalid
);

  localparam int NB    = DW / BW;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  op_t           r_last_load;
  logic          r_wr_pend;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  op_t           w_op;
  logic          w_en;
  logic          w_load;
  logic          w_adv;
  logic          w_is_rd;
  logic          w_is_wr;
  logic          w_fwd;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_mem_rd;
  logic [DW-1:0] w_rd_word;

  assign w_en = ~cen_n;

  always_comb begin
    w_op = DESEL;
    if (!adv_ld) begin
      if (ce) w_op = we_n ? LOAD_RD : LOAD_WR;
    end else if (r_last_load == LOAD_RD) begin
      w_op = BURST_RD;
    end else if (r_last_load == LOAD_WR) begin
      w_op = BURST_WR;
    end
  end

  assign w_load  = w_en & ((w_op == LOAD_RD) | (w_op == LOAD_WR));
  assign w_adv   = w_en & ((w_op == BURST_RD) | (w_op == BURST_WR));
  assign w_is_rd = (w_op == LOAD_RD) | (w_op == BURST_RD);
  assign w_is_wr = (w_op == LOAD_WR) | (w_op == BURST_WR);

  nobl_burst_addr #(.AW(AW)) u_burst (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_adv  (w_adv),
    .i_mode (mode),
    .i_addr (addr),
    .o_addr (w_acc_addr)
  );

  // A read hitting the word committed on this same edge sees the new lanes.
  assign w_mem_rd = r_mem[w_acc_addr];
  assign w_fwd    = r_wr_pend && (r_wr_addr == w_acc_addr);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_fwd
      assign w_rd_word[gi*BW +: BW] = (w_fwd && !bws_n[gi]) ? wdata[gi*BW +: BW]
                                                           : w_mem_rd[gi*BW +: BW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_en && r_wr_pend && !rst) begin
      for (int l = 0; l < NB; l++) begin
        if (!bws_n[l]) r_mem[r_wr_addr][l*BW +: BW] <= wdata[l*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_load <= DESEL;
      r_wr_pend   <= 1'b0;
      r_wr_addr   <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else if (w_en) begin
      if (!adv_ld) r_last_load <= w_op;
      r_wr_pend <= w_is_wr;
      r_wr_addr <= w_acc_addr;
      r_rvalid  <= w_is_rd;
      if (w_is_rd) r_rdata <= w_rd_word;
    end
  end

`ifdef NOBL_PIPE_OUT_EN
  logic [DW-1:0] r_pipe_rdata;
  logic          r_pipe_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_rdata  <= '0;
      r_pipe_rvalid <= 1'b0;
    end else if (w_en) begin
      r_pipe_rdata  <= r_rdata;
      r_pipe_rvalid <= r_rvalid;
    end
  end

  assign rdata  = r_pipe_rdata;
  assign rvalid = r_pipe_rvalid;
`else
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_nobl_sram_param.sv
// Scoreboard bench for nobl_sram_param: directed scenarios plus randomized traffic.
module tb_nobl_sram_param;

  localparam int DW    = 18;
  localparam int BW    = 9;
  localparam int AW    = 10;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 1 << AW;
`ifdef NOBL_PIPE_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen_n = 1'b1;
  logic          ce = 1'b0;
  logic          adv_ld = 1'b0;
  logic          we_n = 1'b1;
  logic [NB-1:0] bws_n = '1;
  logic          mode = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;

  nobl_sram_param #(.DW(DW), .BW(BW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .cen_n  (cen_n),
    .ce     (ce),
    .adv_ld (adv_ld),
    .we_n   (we_n),
    .bws_n  (bws_n),
    .mode   (mode),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            a;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            vec  = 0;
  int            miss = 0;
  int            e_stim = 0;
  int            e_mon  = 0;
  // Reference state: pending write, last load direction (0 none, 1 read, 2 write),
  // burst origin address and number of advances since the load.
  bit            m_pend = 0;
  int            m_pa   = 0;
  int            m_dir  = 0;
  int            m_org  = 0;
  int            m_k    = 0;
  logic          mode_r = 1'b0;

  // Predict the effect of the coming rising edge from the inputs now driven.
  task automatic model_step();
    int  a;
    int  o;
    int  off;
    bit  rd;
    bit  wr;
    exp_t e;
    if (cen_n || rst) return;
    e_stim++;
    if (m_pend) begin
      for (int l = 0; l < NB; l++)
        if (!bws_n[l]) mem_m[m_pa][l*BW +: BW] = wdata[l*BW +: BW];
      m_pend = 0;
    end
    rd = 0;
    wr = 0;
    a  = 0;
    if (!adv_ld) begin
      if (ce) begin
        m_org = int'(addr);
        m_k   = 0;
        m_dir = we_n ? 1 : 2;
        a     = m_org;
        rd    = we_n;
        wr    = !we_n;
      end else begin
        m_dir = 0;
      end
    end else if (m_dir != 0) begin
      m_k++;
      o = m_org % 4;
      if (mode && (m_org % 2 == 1)) off = (o - (m_k % 4) + 4) % 4;
      else                          off = (o + m_k) % 4;
      a  = (m_org / 4) * 4 + off;
      rd = (m_dir == 1);
      wr = (m_dir == 2);
    end
    if (rd) begin
      e.due  = e_stim + LAT - 1;
      e.a    = a;
      e.data = mem_m[a];
      exp_q.push_back(e);
    end
    if (wr) begin
      m_pend = 1;
      m_pa   = a;
    end
  endtask

  task automatic drive(input logic c_n, input logic a_l, input logic c, input logic w_n,
                       input logic [NB-1:0] b, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    cen_n  = c_n;
    adv_ld = a_l;
    ce     = c;
    we_n   = w_n;
    bws_n  = b;
    mode   = mode_r;
    addr   = AW'(a);
    wdata  = d;
    model_step();
  endtask

  task automatic ld_wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    drive(1'b0, 1'b0, 1'b1, 1'b0, b, a, d);
  endtask
  task automatic ld_rd(input int a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    drive(1'b0, 1'b0, 1'b1, 1'b1, b, a, d);
  endtask
  task automatic burst(input logic [DW-1:0] d, input logic [NB-1:0] b);
    drive(1'b0, 1'b1, 1'b0, 1'b1, b, 0, d);
  endtask
  task automatic desel(input logic [DW-1:0] d, input logic [NB-1:0] b);
    drive(1'b0, 1'b0, 1'b0, 1'b1, b, 0, d);
  endtask
  task automatic stall();
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), NB'($urandom),
          int'($urandom_range(0, DEPTH-1)), DW'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    cen_n = 1'b1;
    rst   = 1'b1;
    m_pend = 0;
    m_dir  = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one comparison per rising edge, decoupled from stimulus.
  initial begin : monitor
    logic [DW-1:0] prev_d;
    logic          prev_v;
    bit            en;
    exp_t          e;
    prev_d = '0;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      en = !cen_n && !rst;
      #1;
      vec++;
      if (rst) begin
        if (rdata !== '0 || rvalid !== 1'b0) begin
          miss++;
          $display("FAIL reset_out: rdata=%h rvalid=%b, wanted rdata=0 rvalid=0", rdata, rvalid);
        end
        prev_d = '0;
        prev_v = 1'b0;
      end else if (en) begin
        e_mon++;
        if (exp_q.size() > 0 && exp_q[0].due == e_mon) begin
          e = exp_q.pop_front();
          if (rvalid !== 1'b1 || rdata !== e.data) begin
            miss++;
            $display("FAIL read @%03h edge %0d: rdata=%h rvalid=%b, wanted rdata=%h rvalid=1",
                     e.a, e_mon, rdata, rvalid, e.data);
          end
        end else if (rvalid !== 1'b0) begin
          miss++;
          $display("FAIL idle_rvalid edge %0d: rvalid=%b, wanted 0", e_mon, rvalid);
        end
        prev_d = rdata;
        prev_v = rvalid;
      end else if (rdata !== prev_d || rvalid !== prev_v) begin
        miss++;
        $display("FAIL stall_hold: rdata=%h rvalid=%b, wanted held rdata=%h rvalid=%b",
                 rdata, rvalid, prev_d, prev_v);
      end
    end
  end

  initial begin : stimulus
    int r;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fill every word so later reads have known contents.
    for (int a = 0; a < DEPTH; a++) ld_wr(a, DW'($urandom), '0);
    desel(DW'($urandom), '0);

    // Full-lane write then read back.
    ld_wr('h004, '0, '1);
    desel(18'h3FFFF, 2'b00);
    ld_rd('h004, '0, '1);
    desel('0, '1);

    // Linear write burst then linear read burst.
    mode_r = 1'b0;
    ld_wr('h010, '0, '1);
    burst(18'd1, 2'b00);
    burst(18'd2, 2'b00);
    burst(18'd3, 2'b00);
    desel(18'd4, 2'b00);
    ld_rd('h010, '0, '1);
    burst('0, '1);
    burst('0, '1);
    burst('0, '1);
    desel('0, '1);

    // Interleaved read burst from an odd origin, wrapping past four.
    mode_r = 1'b1;
    ld_rd('h021, '0, '1);
    repeat (4) burst('0, '1);
    desel('0, '1);
    mode_r = 1'b0;

    // Same-edge commit and read: only lane 0 is written.
    ld_wr('h005, '0, '1);
    ld_wr('h005, 18'h00000, 2'b00);
    ld_rd('h005, 18'h3FFFF, 2'b10);
    desel('0, '1);

    // Masked write leaves the word unchanged.
    ld_wr('h006, '0, '1);
    ld_rd('h006, DW'($urandom), 2'b11);
    desel('0, '1);

    // Stall mid-burst.
    ld_rd('h030, '0, '1);
    burst('0, '1);
    repeat (3) stall();
    burst('0, '1);
    burst('0, '1);
    desel('0, '1);

    // Burst after deselect acts as deselect.
    burst('0, '1);
    burst('0, '1);

    // Reset between a write address and its data phase.
    ld_wr('h007, '0, '1);
    do_reset();
    desel(DW'($urandom), 2'b00);
    ld_rd('h007, '0, '1);
    burst('0, '1);
    desel('0, '1);

    // Randomized traffic over a small window to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (i == 1500) do_reset();
      if (r < 10) begin
        stall();
      end else if (r < 55) begin
        burst(DW'($urandom), NB'($urandom));
      end else begin
        mode_r = 1'($urandom);
        drive(1'b0, 1'b0, ($urandom_range(0, 99) < 85), 1'($urandom), NB'($urandom),
              int'($urandom_range(0, 63)), DW'($urandom));
      end
    end

    repeat (4) desel('0, '1);
    @(negedge clk);
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d reads never returned, wanted 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/nobl_sram_param.md
NOBL_SRAM_PARAM -- requirements
Module: nobl_sram_param

Interface
REQ-001 Parameter DW, default 18, data width in bits; SHALL be a multiple of BW.
REQ-002 Parameter BW, default 9, byte-lane width; number of lanes NB = DW/BW.
REQ-003 Parameter AW, default 10, word-address width; depth = 2**AW words.
REQ-004 clk  input  1  rising-edge clock; all state SHALL change only on clk or rst.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cen_n  input  1  clock enable, low-active; high stalls the whole block.
REQ-007 ce  input  1  combined chip select, high-active; sampled only when adv_ld=0.
REQ-008 adv_ld  input  1  1 = burst-advance, 0 = load new address.
REQ-009 we_n  input  1  write (0) or read (1); sampled only when adv_ld=0.
REQ-010 bws_n  input  NB  per-lane write select, low-active, sampled with write data.
REQ-011 mode  input  1  burst order: 1 = interleaved, 0 = linear.
REQ-012 addr  input  AW  word address, sampled when adv_ld=0.
REQ-013 wdata  input  DW  write data, sampled one enabled edge after its address.
REQ-014 rdata  output  DW  read data.
REQ-015 rvalid  output  1  high while rdata holds valid read data.

Function
REQ-016 Enabled edge = rising clk with cen_n=0; cen_n=1 SHALL freeze all registers, with rdata/rvalid held.
REQ-017 Decode on an enabled edge: adv_ld=0 and ce=0 -> DESEL; adv_ld=0, ce=1 -> LOAD_RD or LOAD_WR per we_n; adv_ld=1 -> BURST_RD or BURST_WR, continuing the last load's direction.
REQ-018 adv_ld=1 with the last load being DESEL, or after reset with no load yet, SHALL act as DESEL.
REQ-019 Burst counter: 2-bit offset over addr[1:0]; upper address bits constant.
REQ-020 Linear order (mode=0, or loaded addr[0]=0): +1 mod 4.
REQ-021 Interleaved order (mode=1, loaded addr[0]=1): 1->0->3->2->1; the counter SHALL wrap without limit.
REQ-022 Write (NoBL): an address accepted at enabled edge N takes wdata/bws_n at enabled edge N+1; memory commits at N+1, only lanes with bws_n=0 change.
REQ-023 bws_n all-ones on a write data phase SHALL leave memory unchanged.
REQ-024 Read accepted at edge N: rdata valid and rvalid=1 after edge N (flow-through, latency 1) unless REQ-034 applies.
REQ-025 After a DESEL or write edge, rvalid SHALL be 0 after that edge's latency.
REQ-026 Read at edge N+1 to the address being committed at N+1 SHALL return merged data: new lanes where bws_n=0, old lanes elsewhere.
REQ-027 Back-to-back read/write/read with no idle cycles SHALL be supported at full rate.
REQ-028 An X or Z on wdata SHALL be stored unchanged (no conversion); no other X handling.

Reset
REQ-029 rst=1 SHALL clear rdata=0, rvalid=0, pending write-data phase, burst state (treated as DESEL), and the output register when present.
REQ-030 rst asserted mid-burst or mid-write SHALL abort it; a write data phase due at the next edge SHALL NOT commit.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 After rst deasserts, the first enabled edge is decoded normally per REQ-017/018.

Configuration
REQ-033 Macro NOBL_PIPE_OUT_EN selects the output stage.
REQ-034 Defined: an extra output register is added; read latency 2 enabled edges, rvalid delayed to match, stall-frozen, reset to 0.
REQ-035 Undefined: flow-through, latency 1, as in REQ-024; write timing unchanged in both builds.

Structure
REQ-036 Package nobl_pkg SHALL hold the op enum (DESEL, LOAD_RD, LOAD_WR, BURST_RD, BURST_WR) and the next-offset function for linear/interleaved order.
REQ-037 Sub-module nobl_burst_addr holds the loaded address, burst origin bit and 2-bit counter; it outputs the current word address.
REQ-038 The memory array is inferred in nobl_sram_param; no vendor macros.

Verification
REQ-039 LOAD_WR addr=0x004, then wdata=0x3FFFF, bws_n=00; then LOAD_RD 0x004 -> rdata=0x3FFFF, rvalid=1 after latency.
REQ-040 LOAD_WR 0x010 then BURST_WR x3, mode=0, data 1,2,3,4; read 0x010-0x013 -> 1,2,3,4.
REQ-041 mode=1, LOAD_RD 0x021 + BURST_RD x4 -> addresses 0x021,0x020,0x023,0x022,0x021.
REQ-042 mem[0x05]=0x00000; LOAD_WR 0x05, then data 0x3FFFF with bws_n=10 and same-edge LOAD_RD 0x05 -> rdata=0x001FF.
REQ-043 cen_n=1 for 3 cycles mid-burst -> rdata/rvalid held, burst resumes at the next address.
REQ-044 rst pulse between a LOAD_WR to 0x07 and its data phase -> mem[0x07] unchanged; rdata=0, rvalid=0.
